biquad_coeff_regs: RTL and testbench
====================================

Name: biquad_coeff_regs

Overview:
- Wishbone responder that captures biquad coefficient writes, stages them, and commits them as one atomic update.
- Bus masters program each coefficient group by writing repeatedly to a single group address. A per-group pointer places each word in order.
- A write of bit0 to address 0x00, or a pulse on global_update_i, copies all staged coefficients to the active outputs that drive the biquad DSP datapath.
- Sits between the WB interconnect and the biquad8 filter core.

Parameters:
- COEFF_BITS, 18, width of each coefficient (two's complement Q0.17 fixed-point format).
- ADR_BITS, 7, Wishbone byte-address width.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_n_i  in  1  synchronous active-low reset
- wb_cyc_i  in  1  WB cycle
- wb_stb_i  in  1  WB strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  ADR_BITS  byte address; bits [1:0] ignored
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects; ignored, full-word writes only
- wb_ack_o  out  1  acknowledge
- wb_dat_o  out  32  read data
- global_update_i  in  1  external commit strobe
- zfir_o  out  2xCOEFF_BITS  zero-FIR coefficients
- c_o  out  4xCOEFF_BITS  C coefficients
- incr_o  out  4xCOEFF_BITS  incremental coefficients
- f_o  out  3xCOEFF_BITS  F-chain coefficients
- g_o  out  4xCOEFF_BITS  G-chain coefficients
- fcross_o  out  COEFF_BITS  F cross coefficient
- gcross_o  out  COEFF_BITS  G cross coefficient
- update_o  out  1  one-cycle pulse on each commit

Behaviour:
- Address map:
  - 0x00 CTRL: write bit0 = commit, bit1 = clear all pointers.
  - 0x04 ZFIR (2 words), 0x08 C (4), 0x0C INCR (4), 0x10 F (3), 0x14 G (4), 0x18 FCROSS (1), 0x1C GCROSS (1).
  - All other addresses are unmapped.
- Handshake:
  - wb_ack_o is registered: ack <= cyc & stb & ~ack.
  - Ack therefore rises one cycle after the request and lasts exactly one cycle.
  - The request is acted on in the cycle ack is driven; no wait states.
- Group write:
  - wb_dat_i[COEFF_BITS-1:0] is stored into staging[ptr], then ptr increments.
  - ptr wraps to 0 after index N-1, so the (N+1)th write overwrites index 0.
  - Upper data bits are ignored.
  - Element k of an output bus is the k-th word written after a pointer clear or wrap.
- Commit (CTRL bit0 write, or global_update_i high):
  - All staging registers are copied to the active outputs on the next edge.
  - update_o pulses high for one cycle, aligned with the new output values.
  - Pointers are not affected.
- CTRL write with bit1 and bit0 both set: commit and pointer clear both happen in the same cycle.
- global_update_i coincident with an acked group write: the commit uses pre-write staging contents. The write lands in staging only.
- global_update_i coincident with a CTRL commit: a single commit, a single update_o pulse.
- Reads:
  - CTRL read returns the pointers: ZFIR[0], C[2:1], INCR[4:3], F[6:5], G[8:7], FCROSS[9], GCROSS[10], zeros above.
  - Group read returns staging[ptr], sign-extended to 32 bits, and does not advance ptr.
  - Unmapped addresses: acked, writes dropped, reads return 0.
- Reset (wb_rst_n_i low at a clock edge):
  - All staging, active outputs and pointers go to 0.
  - wb_ack_o = 0, wb_dat_o = 0, update_o = 0.
  - A transaction in flight during reset is dropped and not acked. The master must retry.
- wb_dat_o is registered with ack and holds 0 when ack is low.

Optional Feature:
- BIQUAD_COEFF_READBACK_EN defined: reads behave as described under Behaviour.
- Not defined: wb_dat_o is tied to 0, and the read-mux logic and pointer status are removed. Acks are unchanged.

Decomposition:
- Package biquad_coeff_pkg:
  - Group address localparams (ADR_CTRL, ADR_ZFIR, ...).
  - Group lengths.
  - COEFF_BITS default.
  - typedef coeff_t = logic signed [17:0].
- Sub-module biquad_coeff_group, parameterized NCOEFF:
  - Holds the staging array, the pointer (clog2, minimum 1 bit) and the active array.
  - Inputs: wr strobe, clear, commit.
  - Instantiated seven times.

Test Plan:
- Two writes to 0x04 (0x3FDAF, 0x0375A), then CTRL=1 -> zfir_o = {0x0375A, 0x3FDAF} (index1, index0); update_o high exactly 1 cycle; outputs unchanged before the commit.
- Three writes to 0x10 (0x2205, 0x251, 0x3D162), then a fourth write 0x1111, then commit -> f_o[0] = 0x1111, f_o[1] = 0x251, f_o[2] = 0x3D162; CTRL read pointer field F = 1.
- Write 0x18 = 0x3FC9F, then pulse global_update_i in the same cycle as a write 0x1C = 0x277 -> fcross_o = 0x3FC9F, gcross_o = 0 until a second commit makes it 0x277.
- With readback enabled: read 0x18 after a write of 0x3FC9F -> 0xFFFFFC9F; read of unmapped 0x24 -> 0, acked after 1 cycle.
- Two writes to 0x08, then CTRL = 0x3 -> commit occurs, all pointers 0; next write to 0x08 lands in c index 0.
- Assert reset mid-transaction after three G writes -> no ack for the in-flight transaction, all outputs 0, pointers 0, update_o never pulses.

Source files
------------

// File: rtl/biquad_coeff_pkg.sv
// Shared constants for the biquad coefficient register block: address map,
// group lengths, coefficient width and pointer sizing.
package biquad_coeff_pkg;

    localparam int COEFF_BITS_DEF = 18;
    typedef logic signed [17:0] coeff_t;

    localparam logic [7:0] ADR_CTRL   = 8'h00;
    localparam logic [7:0] ADR_ZFIR   = 8'h04;
    localparam logic [7:0] ADR_C      = 8'h08;
    localparam logic [7:0] ADR_INCR   = 8'h0C;
    localparam logic [7:0] ADR_F      = 8'h10;
    localparam logic [7:0] ADR_G      = 8'h14;
    localparam logic [7:0] ADR_FCROSS = 8'h18;
    localparam logic [7:0] ADR_GCROSS = 8'h1C;

    localparam int N_GROUPS = 7;
    localparam logic [7:0] GROUP_ADR [N_GROUPS] =
        '{ADR_ZFIR, ADR_C, ADR_INCR, ADR_F, ADR_G, ADR_FCROSS, ADR_GCROSS};

    localparam int N_ZFIR   = 2;
    localparam int N_C      = 4;
    localparam int N_INCR   = 4;
    localparam int N_F      = 3;
    localparam int N_G      = 4;
    localparam int N_FCROSS = 1;
    localparam int N_GCROSS = 1;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/biquad_coeff_regs_if.sv
// Wishbone responder bus bundle for the biquad coefficient registers.
// The master drives the request side; the slave returns ack and read data.
interface biquad_coeff_regs_if #(parameter int ADR_BITS = 7);
    logic                wb_cyc_i;
    logic                wb_stb_i;
    logic                wb_we_i;
    logic [ADR_BITS-1:0] wb_adr_i;
    logic [31:0]         wb_dat_i;
    logic [3:0]          wb_sel_i;
    logic                wb_ack_o;
    logic [31:0]         wb_dat_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_ack_o, wb_dat_o
    );
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/biquad_coeff_group.sv
// One coefficient group: write pointer, staging array and active array.
// Writes fill staging in order with wrap; commit copies staging to active in one edge.
module biquad_coeff_group
    import biquad_coeff_pkg::*;
#(
    parameter int NCOEFF = 4,
    parameter int CB     = COEFF_BITS_DEF,
    localparam int PW    = ptr_bits(NCOEFF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr,
    input  logic [CB-1:0]      i_wr_dat,
    input  logic               i_clr,
    input  logic               i_commit,
    output logic [NCOEFF*CB-1:0] o_active,
    output logic [CB-1:0]      o_stage_cur,
    output logic [PW-1:0]      o_ptr
);

    logic [CB-1:0] r_stage  [NCOEFF];
    logic [CB-1:0] r_active [NCOEFF];
    logic [PW-1:0] r_ptr;

    // Commit samples staging before this edge's write, so a coincident write stays staged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
            for (int k = 0; k < NCOEFF; k++) begin
                r_stage[k]  <= '0;
                r_active[k] <= '0;
            end
        end else begin
            if (i_commit) begin
                for (int k = 0; k < NCOEFF; k++) r_active[k] <= r_stage[k];
            end
            if (i_wr) begin
                for (int k = 0; k < NCOEFF; k++) begin
                    if (r_ptr == PW'(k)) r_stage[k] <= i_wr_dat;
                end
                r_ptr <= (r_ptr == PW'(NCOEFF-1)) ? '0 : r_ptr + 1'b1;
            end
            if (i_clr) r_ptr <= '0;
        end
    end

    always_comb begin
        o_active    = '0;
        o_stage_cur = '0;
        for (int k = 0; k < NCOEFF; k++) begin
            o_active[k*CB +: CB] = r_active[k];
            if (r_ptr == PW'(k)) o_stage_cur = r_stage[k];
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/biquad_coeff_regs.sv
// Wishbone coefficient register file for biquad8: staged group writes, atomic commit.
// Ack one cycle after request, never stalls; readback gated by BIQUAD_COEFF_READBACK_EN.
module biquad_coeff_regs
    import biquad_coeff_pkg::*;
#(
    parameter int COEFF_BITS = COEFF_BITS_DEF,
    parameter int ADR_BITS   = 7
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    biquad_coeff_regs_if.slave      bus,
    input  logic                    global_update_i,
    output logic [2*COEFF_BITS-1:0] zfir_o,
    output logic [4*COEFF_BITS-1:0] c_o,
    output logic [4*COEFF_BITS-1:0] incr_o,
    output logic [3*COEFF_BITS-1:0] f_o,
    output logic [4*COEFF_BITS-1:0] g_o,
    output logic [COEFF_BITS-1:0]   fcross_o,
    output logic [COEFF_BITS-1:0]   gcross_o,
    output logic                    update_o
);

    logic                       r_ack;
    logic                       r_upd;
    logic [ADR_BITS-3:0]        w_word;
    logic                       w_req, w_wr, w_ctrl_hit, w_commit, w_clr;
    logic [N_GROUPS-1:0]        w_hit;
    logic [COEFF_BITS-1:0]      w_wdat;
    logic [N_GROUPS-1:0][COEFF_BITS-1:0] w_cur;
    logic [ptr_bits(N_ZFIR)-1:0]   w_ptr_zfir;
    logic [ptr_bits(N_C)-1:0]      w_ptr_c;
    logic [ptr_bits(N_INCR)-1:0]   w_ptr_incr;
    logic [ptr_bits(N_F)-1:0]      w_ptr_f;
    logic [ptr_bits(N_G)-1:0]      w_ptr_g;
    logic [ptr_bits(N_FCROSS)-1:0] w_ptr_fc;
    logic [ptr_bits(N_GCROSS)-1:0] w_ptr_gc;
    logic                       w_unused;

    assign w_word     = bus.wb_adr_i[ADR_BITS-1:2];
    assign w_req      = bus.wb_cyc_i & bus.wb_stb_i & ~r_ack;
    assign w_wr       = w_req & bus.wb_we_i;
    assign w_wdat     = bus.wb_dat_i[COEFF_BITS-1:0];
    assign w_ctrl_hit = (w_word == (ADR_BITS-2)'(ADR_CTRL >> 2));
    assign w_commit   = (w_wr & w_ctrl_hit & bus.wb_dat_i[CTRL_COMMIT_BIT]) | global_update_i;
    assign w_clr      = w_wr & w_ctrl_hit & bus.wb_dat_i[CTRL_CLEAR_BIT];

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N_GROUPS; i++) begin
            w_hit[i] = (w_word == (ADR_BITS-2)'(GROUP_ADR[i] >> 2));
        end
    end

    biquad_coeff_group #(.NCOEFF(N_ZFIR), .CB(COEFF_BITS)) u_zfir (
        .clk(wb_clk_i), .rst_n(wb_rst_n_i), .i_wr(w_wr & w_hit[0]), .i_wr_dat(w_wdat),
        .i_clr(w_clr), .i_commit(w_commit), .o_active(zfir_o), .o_stage_cur(w_cur[0]), .o_ptr(w_ptr_zfir));
    biquad_coeff_group #(.NCOEFF(N_C), .CB(COEFF_BITS)) u_c (
        .clk(wb_clk_i), .rst_n(wb_rst_n_i), .i_wr(w_wr & w_hit[1]), .i_wr_dat(w_wdat),
        .i_clr(w_clr), .i_commit(w_commit), .o_active(c_o), .o_stage_cur(w_cur[1]), .o_ptr(w_ptr_c));
    biquad_coeff_group #(.NCOEFF(N_INCR), .CB(COEFF_BITS)) u_incr (
        .clk(wb_clk_i), .rst_n(wb_rst_n_i), .i_wr(w_wr & w_hit[2]), .i_wr_dat(w_wdat),
        .i_clr(w_clr), .i_commit(w_commit), .o_active(incr_o), .o_stage_cur(w_cur[2]), .o_ptr(w_ptr_incr));
    biquad_coeff_group #(.NCOEFF(N_F), .CB(COEFF_BITS)) u_f (
        .clk(wb_clk_i), .rst_n(wb_rst_n_i), .i_wr(w_wr & w_hit[3]), .i_wr_dat(w_wdat),
        .i_clr(w_clr), .i_commit(w_commit), .o_active(f_o), .o_stage_cur(w_cur[3]), .o_ptr(w_ptr_f));
    biquad_coeff_group #(.NCOEFF(N_G), .CB(COEFF_BITS)) u_g (
        .clk(wb_clk_i), .rst_n(wb_rst_n_i), .i_wr(w_wr & w_hit[4]), .i_wr_dat(w_wdat),
        .i_clr(w_clr), .i_commit(w_commit), .o_active(g_o), .o_stage_cur(w_cur[4]), .o_ptr(w_ptr_g));
    biquad_coeff_group #(.NCOEFF(N_FCROSS), .CB(COEFF_BITS)) u_fcross (
        .clk(wb_clk_i), .rst_n(wb_rst_n_i), .i_wr(w_wr & w_hit[5]), .i_wr_dat(w_wdat),
        .i_clr(w_clr), .i_commit(w_commit), .o_active(fcross_o), .o_stage_cur(w_cur[5]), .o_ptr(w_ptr_fc));
    biquad_coeff_group #(.NCOEFF(N_GCROSS), .CB(COEFF_BITS)) u_gcross (
        .clk(wb_clk_i), .rst_n(wb_rst_n_i), .i_wr(w_wr & w_hit[6]), .i_wr_dat(w_wdat),
        .i_clr(w_clr), .i_commit(w_commit), .o_active(gcross_o), .o_stage_cur(w_cur[6]), .o_ptr(w_ptr_gc));

    // Reset drops any request in flight: no ack is produced for it.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_ack <= 1'b0;
            r_upd <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_upd <= w_commit;
        end
    end

    assign bus.wb_ack_o = r_ack;
    assign update_o     = r_upd;

`ifdef BIQUAD_COEFF_READBACK_EN
    logic [31:0] w_rdat;
    logic [31:0] r_dat;

    always_comb begin
        w_rdat = '0;
        if (w_ctrl_hit) begin
            w_rdat = {21'b0, w_ptr_gc, w_ptr_fc, w_ptr_g, w_ptr_f, w_ptr_incr, w_ptr_c, w_ptr_zfir};
        end
        for (int i = 0; i < N_GROUPS; i++) begin
            if (w_hit[i]) w_rdat = {{(32-COEFF_BITS){w_cur[i][COEFF_BITS-1]}}, w_cur[i]};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_dat <= '0;
        end else if (w_req && !bus.wb_we_i) begin
            r_dat <= w_rdat;
        end else begin
            r_dat <= '0;
        end
    end

    assign bus.wb_dat_o = r_dat;
    assign w_unused = &{1'b0, bus.wb_sel_i, bus.wb_adr_i[1:0], bus.wb_dat_i[31:COEFF_BITS]};
`else
    assign bus.wb_dat_o = '0;
    assign w_unused = &{1'b0, bus.wb_sel_i, bus.wb_adr_i[1:0], bus.wb_dat_i[31:COEFF_BITS], w_cur,
                        w_ptr_gc, w_ptr_fc, w_ptr_g, w_ptr_f, w_ptr_incr, w_ptr_c, w_ptr_zfir};
`endif

endmodule

// File: tb/tb_biquad_coeff_regs.sv
// Bench for biquad_coeff_regs: directed plan scenarios plus randomized traffic
// checked against a per-group staging/active array reference model.
module tb_biquad_coeff_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        global_update_i = 1'b0;
    logic [35:0] zfir_o;
    logic [71:0] c_o, incr_o, g_o;
    logic [53:0] f_o;
    logic [17:0] fcross_o, gcross_o;
    logic        update_o;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    biquad_coeff_regs_if #(.ADR_BITS(7)) bus ();

    biquad_coeff_regs #(.COEFF_BITS(18), .ADR_BITS(7)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bus), .global_update_i(global_update_i),
        .zfir_o(zfir_o), .c_o(c_o), .incr_o(incr_o), .f_o(f_o), .g_o(g_o),
        .fcross_o(fcross_o), .gcross_o(gcross_o), .update_o(update_o)
    );

    wire [341:0] w_obs = {zfir_o, c_o, incr_o, f_o, g_o, fcross_o, gcross_o};

    // Reference model: group g lives at word address g+1.
    int          len [7] = '{2, 4, 4, 3, 4, 1, 1};
    logic [17:0] stg [7][4];
    logic [17:0] act [7][4];
    int          ptr [7];

    task automatic m_reset();
        for (int g = 0; g < 7; g++) begin
            ptr[g] = 0;
            for (int k = 0; k < 4; k++) begin stg[g][k] = '0; act[g][k] = '0; end
        end
    endtask

    task automatic m_commit();
        for (int g = 0; g < 7; g++)
            for (int k = 0; k < 4; k++) act[g][k] = stg[g][k];
    endtask

    task automatic m_write(input int word, input logic [31:0] dat, input logic glob);
        if (glob) m_commit();
        if (word == 0) begin
            if (dat[0]) m_commit();
            if (dat[1]) for (int g = 0; g < 7; g++) ptr[g] = 0;
        end else if (word >= 1 && word <= 7) begin
            stg[word-1][ptr[word-1]] = dat[17:0];
            ptr[word-1] = (ptr[word-1] + 1) % len[word-1];
        end
    endtask

    function automatic logic [31:0] m_read(input int word);
        logic [31:0] r;
        logic [17:0] s;
        r = '0;
`ifdef BIQUAD_COEFF_READBACK_EN
        if (word == 0) begin
            r = 32'(ptr[0]) | (32'(ptr[1]) << 1) | (32'(ptr[2]) << 3) | (32'(ptr[3]) << 5)
              | (32'(ptr[4]) << 7) | (32'(ptr[5]) << 9) | (32'(ptr[6]) << 10);
        end else if (word >= 1 && word <= 7) begin
            s = stg[word-1][ptr[word-1]];
            r = {{14{s[17]}}, s};
        end
`endif
        return r;
    endfunction

    function automatic logic [341:0] exp_all();
        logic [341:0] v;
        v = '0;
        for (int g = 0; g < 7; g++)
            for (int k = len[g] - 1; k >= 0; k--) v = {v[323:0], act[g][k]};
        return v;
    endfunction

    task automatic xfer(input logic we, input logic [6:0] adr, input logic [31:0] dat, input logic glob,
                        output logic [31:0] rdat, output logic upd, output int lat);
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr;  bus.wb_dat_i = dat;  bus.wb_sel_i = 4'($urandom);
        global_update_i = glob;
        lat = 0;
        do begin
            @(posedge clk); #1;
            global_update_i = 1'b0;
            lat++;
        end while (!bus.wb_ack_o && lat < 8);
        if (!bus.wb_ack_o) begin
            checks++; errors++;
            $display("FAIL ack_timeout adr=%h got no ack within %0d cycles", adr, lat);
        end
        rdat = bus.wb_dat_o;
        upd  = update_o;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    endtask

    task automatic bus_write(input logic [6:0] adr, input logic [31:0] dat, input logic glob,
                             output logic upd, output logic [31:0] rdat);
        int lat;
        xfer(1'b1, adr, dat, glob, rdat, upd, lat);
        m_write(int'(adr[6:2]), dat, glob);
    endtask

    task automatic bus_read(input logic [6:0] adr, input logic glob,
                            output logic [31:0] rdat, output logic upd, output int lat);
        xfer(1'b0, adr, 32'($urandom), glob, rdat, upd, lat);
        if (glob) m_commit();
    endtask

    task automatic test_reset();
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        rst_n = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b expected 0", bus.wb_ack_o); end
        checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h expected 0", bus.wb_dat_o); end
        checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL reset_update got %b expected 0", update_o); end
        checks++; if (w_obs !== exp_all()) begin errors++; $display("FAIL reset_outputs got %h expected %h", w_obs, exp_all()); end
    endtask

    task automatic test_zfir();
        logic upd; logic [31:0] rd; logic [35:0] ez;
        ez = {18'h0375A, 18'h3FDAF};
        bus_write(7'h04, 32'hABC3FDAF, 1'b0, upd, rd);
        bus_write(7'h04, 32'h5550375A, 1'b0, upd, rd);
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL zfir_no_update got %b expected 0", upd); end
        checks++; if (w_obs !== exp_all()) begin errors++; $display("FAIL zfir_precommit got %h expected %h", w_obs, exp_all()); end
        bus_write(7'h00, 32'h1, 1'b0, upd, rd);
        checks++; if (upd !== 1'b1) begin errors++; $display("FAIL zfir_update got %b expected 1", upd); end
        checks++; if (zfir_o !== ez) begin errors++; $display("FAIL zfir_value got %h expected %h", zfir_o, ez); end
        @(posedge clk); #1;
        checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL zfir_update_width got %b expected 0", update_o); end
    endtask

    task automatic test_f_wrap();
        logic upd; logic [31:0] rd, exp_rd; int lat;
        bus_write(7'h10, 32'h00002205, 1'b0, upd, rd);
        bus_write(7'h10, 32'h00000251, 1'b0, upd, rd);
        bus_write(7'h10, 32'h0003D162, 1'b0, upd, rd);
        bus_write(7'h10, 32'hFFF01111, 1'b0, upd, rd);
        bus_write(7'h00, 32'h1, 1'b0, upd, rd);
        checks++; if (f_o[17:0] !== 18'h01111) begin errors++; $display("FAIL f0 got %h expected 01111", f_o[17:0]); end
        checks++; if (f_o[35:18] !== 18'h00251) begin errors++; $display("FAIL f1 got %h expected 00251", f_o[35:18]); end
        checks++; if (f_o[53:36] !== 18'h3D162) begin errors++; $display("FAIL f2 got %h expected 3D162", f_o[53:36]); end
        exp_rd = m_read(0);
        bus_read(7'h00, 1'b0, rd, upd, lat);
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL ctrl_read got %h expected %h", rd, exp_rd); end
`ifdef BIQUAD_COEFF_READBACK_EN
        checks++; if (rd[6:5] !== 2'd1) begin errors++; $display("FAIL f_ptr got %0d expected 1", rd[6:5]); end
`endif
    endtask

    task automatic test_global_coincident();
        logic upd; logic [31:0] rd;
        bus_write(7'h18, 32'h0003FC9F, 1'b0, upd, rd);
        bus_write(7'h1C, 32'h00000277, 1'b1, upd, rd);
        checks++; if (upd !== 1'b1) begin errors++; $display("FAIL glob_update got %b expected 1", upd); end
        checks++; if (fcross_o !== 18'h3FC9F) begin errors++; $display("FAIL glob_fcross got %h expected 3FC9F", fcross_o); end
        checks++; if (gcross_o !== 18'h0) begin errors++; $display("FAIL glob_gcross_old got %h expected 0", gcross_o); end
        bus_write(7'h00, 32'h1, 1'b0, upd, rd);
        checks++; if (gcross_o !== 18'h00277) begin errors++; $display("FAIL glob_gcross_new got %h expected 00277", gcross_o); end
    endtask

    task automatic test_readback();
        logic upd; logic [31:0] rd, exp_rd; int lat;
`ifdef BIQUAD_COEFF_READBACK_EN
        exp_rd = 32'hFFFFFC9F;
`else
        exp_rd = 32'h0;
`endif
        bus_read(7'h18, 1'b0, rd, upd, lat);
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL read_fcross got %h expected %h", rd, exp_rd); end
        bus_read(7'h24, 1'b0, rd, upd, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL read_unmapped got %h expected 0", rd); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL read_latency got %0d expected 1", lat); end
    endtask

    task automatic test_ctrl_clear();
        logic upd; logic [31:0] rd, exp_rd, x; int lat;
        bus_write(7'h08, $urandom, 1'b0, upd, rd);
        bus_write(7'h08, $urandom, 1'b0, upd, rd);
        bus_write(7'h00, 32'h3, 1'b0, upd, rd);
        checks++; if (upd !== 1'b1) begin errors++; $display("FAIL clr_update got %b expected 1", upd); end
        checks++; if (w_obs !== exp_all()) begin errors++; $display("FAIL clr_outputs got %h expected %h", w_obs, exp_all()); end
        exp_rd = m_read(0);
        bus_read(7'h00, 1'b0, rd, upd, lat);
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL clr_ptrs got %h expected %h", rd, exp_rd); end
        x = $urandom;
        bus_write(7'h08, x, 1'b0, upd, rd);
        bus_write(7'h00, 32'h1, 1'b0, upd, rd);
        checks++; if (c_o[17:0] !== x[17:0]) begin errors++; $display("FAIL clr_c0 got %h expected %h", c_o[17:0], x[17:0]); end
    endtask

    task automatic test_random();
        logic upd, glob, exp_upd; logic [31:0] rd, dat, exp_rd; logic [6:0] adr; int word, lat;
        for (int n = 0; n < 80; n++) begin
            word = $urandom_range(0, 9);
            adr  = {5'(word), 2'($urandom)};
            glob = ($urandom_range(0, 4) == 0);
            dat  = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                exp_upd = glob | (word == 0 && dat[0]);
                bus_write(adr, dat, glob, upd, rd);
                checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rnd_wr_dat n=%0d got %h expected 0", n, rd); end
            end else begin
                exp_upd = glob;
                exp_rd  = m_read(word);
                bus_read(adr, glob, rd, upd, lat);
                checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rd n=%0d adr=%h got %h expected %h", n, adr, rd, exp_rd); end
            end
            checks++; if (upd !== exp_upd) begin errors++; $display("FAIL rnd_update n=%0d got %b expected %b", n, upd, exp_upd); end
            checks++; if (w_obs !== exp_all()) begin errors++; $display("FAIL rnd_outputs n=%0d got %h expected %h", n, w_obs, exp_all()); end
        end
    endtask

    task automatic test_reset_midflight();
        logic upd; logic [31:0] rd, exp_rd, x; int lat;
        for (int i = 0; i < 3; i++) bus_write(7'h14, $urandom, 1'b0, upd, rd);
        @(posedge clk); #1;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1;
        bus.wb_adr_i = 7'h00; bus.wb_dat_i = 32'h1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_inflight_ack cyc=%0d got %b expected 0", i, bus.wb_ack_o); end
            checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL rst_inflight_update cyc=%0d got %b expected 0", i, update_o); end
        end
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        rst_n = 1'b1;
        m_reset();
        @(posedge clk); #1;
        checks++; if (w_obs !== exp_all()) begin errors++; $display("FAIL rst_outputs got %h expected %h", w_obs, exp_all()); end
        checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL rst_update got %b expected 0", update_o); end
        exp_rd = m_read(0);
        bus_read(7'h00, 1'b0, rd, upd, lat);
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rst_ptrs got %h expected %h", rd, exp_rd); end
        x = $urandom;
        bus_write(7'h14, x, 1'b0, upd, rd);
        bus_write(7'h00, 32'h1, 1'b0, upd, rd);
        checks++; if (g_o[17:0] !== x[17:0]) begin errors++; $display("FAIL rst_g0 got %h expected %h", g_o[17:0], x[17:0]); end
    endtask

    initial begin
        test_reset();
        test_zfir();
        test_f_wrap();
        test_global_coincident();
        test_readback();
        test_ctrl_clear();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
